// File: rtl/octree_mem_pkg.sv
// Shared types and constants for the octree / BFS memory port.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: default address width, requester channel indices,
// arbitration policy encodings and the arbiter FSM state type.
package octree_mem_pkg;

    localparam int DEF_ADDR_SIZE = 9;

    // Requester channel assignment on the shared BRAM port.
    localparam int CH_OCTREE = 0;
    localparam int CH_BFS    = 1;

    // Arbitration policy encodings for the MODE parameter.
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mux_nto1.sv
// One-hot N:1 selector of W-bit lanes; output is zero when no select bit is set.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   sel  - one-hot lane select (N bits)
//   din  - packed lanes, lane k at [k*W +: W]
//   dout - selected lane, or zero
module mux_nto1 #(
    parameter int W = 1,
    parameter int N = 2
) (
    input  logic [N-1:0]   sel,
    input  logic [N*W-1:0] din,
    output logic [W-1:0]   dout
);

    // AND-OR structure: a one-hot select yields the chosen lane, an
    // all-zero select yields zero without any priority chain.
    always_comb begin
        dout = '0;
        for (int k = 0; k < N; k++) begin
            if (sel[k]) begin
                dout = dout | din[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel ownership arbiter for one synchronous BRAM port (fixed priority or round robin).
// Latency: grant one cycle after a request is sampled; read data RD_LAT cycles after acceptance.
// Backpressure: a requester waits with req/addr/data held until it sees its o_gnt bit; lock holds ownership.
//
// Ports:
//   i_clk, i_rst_n          - clock, async active-low reset
//   i_req/i_lock/i_we       - per-channel request, hold-grant, write enable
//   i_addr/i_wdata          - packed per-channel address / write data
//   o_gnt                   - registered one-hot grant (zero when idle)
//   o_rvalid/o_rdata        - one-hot read return valid, shared read data
//   o_mem_en/we/addr/wdata  - BRAM port drive
//   i_mem_rdata             - BRAM read data
module mem_port_arbiter
    import octree_mem_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int DATA_W    = 32,
    parameter int N_CH      = 2,
    parameter int RD_LAT    = 1,
    parameter int MODE      = ARB_FIXED,
    parameter int MAX_BURST = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_CH-1:0]           i_req,
    input  logic [N_CH-1:0]           i_lock,
    input  logic [N_CH-1:0]           i_we,
    input  logic [N_CH*ADDR_SIZE-1:0] i_addr,
    input  logic [N_CH*DATA_W-1:0]    i_wdata,
    output logic [N_CH-1:0]           o_gnt,
    output logic [N_CH-1:0]           o_rvalid,
    output logic [DATA_W-1:0]         o_rdata,
    output logic                      o_mem_en,
    output logic                      o_mem_we,
    output logic [ADDR_SIZE-1:0]      o_mem_addr,
    output logic [DATA_W-1:0]         o_mem_wdata,
    input  logic [DATA_W-1:0]         i_mem_rdata
);

    localparam int CW = $clog2(N_CH);
    localparam int BW = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]   BURST_MAX  = BW'(MAX_BURST);
    localparam logic [BW-1:0]   BURST_LAST = (MAX_BURST == 0) ? '0 : BW'(MAX_BURST - 1);
    localparam logic [N_CH-1:0] CH_ONE     = {{(N_CH-1){1'b0}}, 1'b1};

    arb_state_t      state;
    logic [CW-1:0]   owner;
    logic [CW-1:0]   rr_ptr;
    logic [BW-1:0]   burst_cnt;

    logic            owned;
    logic            owner_req;
    logic            owner_lock;
    logic            accept;
    logic            cap_hit;
    logic            release_now;
    logic            arb_en;
    logic [N_CH-1:0] cand;
    logic            win_found;
    logic [CW-1:0]   win_idx;
    logic [N_CH-1:0] win_oh;
    logic [CW-1:0]   rr_next;
    logic            sel_we;

    logic [RD_LAT-1:0] pipe_vld;
    logic [CW-1:0]     pipe_ch [RD_LAT];

    // ------------------------------------------------------------------
    // Ownership status and release detection
    // ------------------------------------------------------------------
    assign owned      = (state == ST_OWNED);
    assign owner_req  = i_req[owner];
    assign owner_lock = i_lock[owner];
    assign accept     = owned & owner_req;

    // The cap fires on the access that completes the burst; a held lock
    // suppresses it (the counter then saturates and the cap stays quiet).
    assign cap_hit     = (MAX_BURST != 0) && accept && (burst_cnt == BURST_LAST) && !owner_lock;
    assign release_now = owned && ((!owner_req && !owner_lock) || cap_hit);
    assign arb_en      = !owned || release_now;

    // A releasing owner sits out this arbitration so a forced release
    // always hands over when anyone else is waiting.
    always_comb begin
        cand = i_req | i_lock;
        if (release_now) begin
            cand[owner] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Winner selection: lowest index, or first set bit from rr_ptr upward
    // ------------------------------------------------------------------
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (MODE == ARB_RR) begin
                idx = (int'(rr_ptr) + i) % N_CH;
            end else begin
                idx = i;
            end
            if (!win_found && cand[CW'(idx)]) begin
                win_found = 1'b1;
                win_idx   = CW'(idx);
            end
        end
    end

    assign win_oh  = CH_ONE << win_idx;
    assign rr_next = CW'((int'(win_idx) + 1) % N_CH);

    // ------------------------------------------------------------------
    // Ownership FSM with registered grant
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            owner     <= '0;
            o_gnt     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else if (arb_en) begin
            burst_cnt <= '0;
            if (win_found) begin
                state <= ST_OWNED;
                owner <= win_idx;
                o_gnt <= win_oh;
                if (MODE == ARB_RR) begin
                    rr_ptr <= rr_next;
                end
            end else begin
                state <= ST_IDLE;
                o_gnt <= '0;
            end
        end else if (accept && (MAX_BURST != 0) && (burst_cnt != BURST_MAX)) begin
            burst_cnt <= burst_cnt + BW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Memory port drive, muxed by the registered grant
    // ------------------------------------------------------------------
    mux_nto1 #(.W(ADDR_SIZE), .N(N_CH)) u_addr_mux (
        .sel  (o_gnt),
        .din  (i_addr),
        .dout (o_mem_addr)
    );

    mux_nto1 #(.W(DATA_W), .N(N_CH)) u_wdata_mux (
        .sel  (o_gnt),
        .din  (i_wdata),
        .dout (o_mem_wdata)
    );

    mux_nto1 #(.W(1), .N(N_CH)) u_we_mux (
        .sel  (o_gnt),
        .din  (i_we),
        .dout (sel_we)
    );

    assign o_mem_en = accept;
    assign o_mem_we = sel_we & accept;

    // ------------------------------------------------------------------
    // Read return pipe: tags each accepted read with its channel so data
    // lands on the issuer even if ownership moves while it is in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pipe_vld <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                pipe_ch[s] <= '0;
            end
        end else begin
            pipe_vld[0] <= accept & ~sel_we;
            pipe_ch[0]  <= owner;
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_ch[s]  <= pipe_ch[s-1];
            end
        end
    end

    assign o_rvalid = pipe_vld[RD_LAT-1] ? (CH_ONE << pipe_ch[RD_LAT-1]) : '0;
    assign o_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (default, 4-ch round robin, burst-capped RD_LAT=3).
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_port_arbiter;
    import octree_mem_pkg::*;

    typedef struct {
        int          ch;
        logic [31:0] data;
        int          due;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    sb_t q_a[$];
    sb_t q_c[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A: default parameters ----------------
    logic [1:0]  a_req = '0, a_lock = '0, a_we = '0;
    logic [17:0] a_addr = '0;
    logic [63:0] a_wdata = '0;
    logic [1:0]  a_gnt, a_rvalid;
    logic [31:0] a_rdata, a_mem_wdata, a_mem_rdata;
    logic        a_mem_en, a_mem_we;
    logic [8:0]  a_mem_addr;

    mem_port_arbiter dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(a_req), .i_lock(a_lock), .i_we(a_we),
        .i_addr(a_addr), .i_wdata(a_wdata), .o_gnt(a_gnt), .o_rvalid(a_rvalid),
        .o_rdata(a_rdata), .o_mem_en(a_mem_en), .o_mem_we(a_mem_we),
        .o_mem_addr(a_mem_addr), .o_mem_wdata(a_mem_wdata), .i_mem_rdata(a_mem_rdata)
    );

    // ---------------- instance B: 4 channels, round robin, cap 2 ----------------
    logic [3:0]   b_req = '0, b_lock = '0, b_we = '0;
    logic [35:0]  b_addr = '0;
    logic [127:0] b_wdata = '0;
    logic [3:0]   b_gnt, b_rvalid;
    logic [31:0]  b_rdata, b_mem_wdata;
    logic [31:0]  b_mem_rdata = '0;
    logic         b_mem_en, b_mem_we;
    logic [8:0]   b_mem_addr;

    mem_port_arbiter #(.N_CH(4), .MODE(ARB_RR), .MAX_BURST(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(b_req), .i_lock(b_lock), .i_we(b_we),
        .i_addr(b_addr), .i_wdata(b_wdata), .o_gnt(b_gnt), .o_rvalid(b_rvalid),
        .o_rdata(b_rdata), .o_mem_en(b_mem_en), .o_mem_we(b_mem_we),
        .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata), .i_mem_rdata(b_mem_rdata)
    );

    // ---------------- instance C: fixed priority, cap 2, RD_LAT 3 ----------------
    logic [1:0]  c_req = '0, c_lock = '0, c_we = '0;
    logic [17:0] c_addr = '0;
    logic [63:0] c_wdata = '0;
    logic [1:0]  c_gnt, c_rvalid;
    logic [31:0] c_rdata, c_mem_wdata, c_mem_rdata, c_p1, c_p2;
    logic        c_mem_en, c_mem_we;
    logic [8:0]  c_mem_addr;

    mem_port_arbiter #(.MAX_BURST(2), .RD_LAT(3)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(c_req), .i_lock(c_lock), .i_we(c_we),
        .i_addr(c_addr), .i_wdata(c_wdata), .o_gnt(c_gnt), .o_rvalid(c_rvalid),
        .o_rdata(c_rdata), .o_mem_en(c_mem_en), .o_mem_we(c_mem_we),
        .o_mem_addr(c_mem_addr), .o_mem_wdata(c_mem_wdata), .i_mem_rdata(c_mem_rdata)
    );

    // Memory contents are a fixed function of address.
    function automatic logic [31:0] fdat(input logic [8:0] a);
        return 32'hC0DE_0000 | {23'd0, a};
    endfunction

    // BRAM models: 1-cycle for A, 3-cycle for C.
    always @(posedge clk) begin
        if (a_mem_en && !a_mem_we) a_mem_rdata <= fdat(a_mem_addr);
        c_p1        <= (c_mem_en && !c_mem_we) ? fdat(c_mem_addr) : 32'hDEAD_BEEF;
        c_p2        <= c_p1;
        c_mem_rdata <= c_p2;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Scoreboard consumer: pops expected reads as o_rvalid appears.
    task automatic monitor_loop();
        sb_t e;
        logic [1:0] exp_rv;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                while (q_a.size() > 0 && q_a[0].due < cyc) begin
                    n_total++;
                    e = q_a.pop_front();
                    $display("FAIL sb_a_late: no rvalid by cycle %0d, required ch%0d at cycle %0d", cyc, e.ch, e.due);
                end
                if (a_rvalid !== 2'b00) begin
                    n_total++;
                    if (q_a.size() == 0) begin
                        $display("FAIL sb_a_stale: rvalid=%b rdata=%h, required no rvalid", a_rvalid, a_rdata);
                    end else begin
                        e = q_a.pop_front();
                        exp_rv = 2'b01 << e.ch;
                        if (a_rvalid !== exp_rv || a_rdata !== e.data || cyc != e.due)
                            $display("FAIL sb_a_read: rvalid=%b rdata=%h cyc=%0d, required rvalid=%b rdata=%h cyc=%0d",
                                     a_rvalid, a_rdata, cyc, exp_rv, e.data, e.due);
                        else n_pass++;
                    end
                end
                while (q_c.size() > 0 && q_c[0].due < cyc) begin
                    n_total++;
                    e = q_c.pop_front();
                    $display("FAIL sb_c_late: no rvalid by cycle %0d, required ch%0d at cycle %0d", cyc, e.ch, e.due);
                end
                if (c_rvalid !== 2'b00) begin
                    n_total++;
                    if (q_c.size() == 0) begin
                        $display("FAIL sb_c_stale: rvalid=%b rdata=%h, required no rvalid", c_rvalid, c_rdata);
                    end else begin
                        e = q_c.pop_front();
                        exp_rv = 2'b01 << e.ch;
                        if (c_rvalid !== exp_rv || c_rdata !== e.data || cyc != e.due)
                            $display("FAIL sb_c_read: rvalid=%b rdata=%h cyc=%0d, required rvalid=%b rdata=%h cyc=%0d",
                                     c_rvalid, c_rdata, cyc, exp_rv, e.data, e.due);
                        else n_pass++;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_total++;
        if ({a_gnt, a_rvalid, a_mem_en, a_mem_we} !== 6'b0)
            $display("FAIL reset_ctrl_a: gnt=%b rvalid=%b en=%b we=%b, required all 0", a_gnt, a_rvalid, a_mem_en, a_mem_we);
        else n_pass++;
        n_total++;
        if (a_mem_addr !== 9'h0 || a_mem_wdata !== 32'h0)
            $display("FAIL reset_data_a: addr=%h wdata=%h, required 0", a_mem_addr, a_mem_wdata);
        else n_pass++;
        n_total++;
        if (b_gnt !== 4'h0 || c_gnt !== 2'b00 || b_rvalid !== 4'h0 || c_rvalid !== 2'b00)
            $display("FAIL reset_bc: b_gnt=%b c_gnt=%b b_rv=%b c_rv=%b, required 0", b_gnt, c_gnt, b_rvalid, c_rvalid);
        else n_pass++;
        @(negedge clk); #2; rst_n = 1'b1;
        tick(); settle();
        n_total++;
        if (a_gnt !== 2'b00) $display("FAIL idle_after_reset: gnt=%b, required 00", a_gnt);
        else n_pass++;
    endtask

    task automatic test_single();
        tick(); a_req = 2'b10; a_we = 2'b00; a_addr = {9'h1A5, 9'h000}; settle();
        n_total++;
        if (a_gnt !== 2'b00) $display("FAIL single_pre_gnt: gnt=%b, required 00", a_gnt);
        else n_pass++;
        tick(); settle();
        n_total++;
        if (a_gnt !== 2'b10) $display("FAIL single_gnt: gnt=%b, required 10", a_gnt);
        else n_pass++;
        n_total++;
        if (a_mem_en !== 1'b1 || a_mem_we !== 1'b0 || a_mem_addr !== 9'h1A5)
            $display("FAIL single_access: en=%b we=%b addr=%h, required 1 0 1a5", a_mem_en, a_mem_we, a_mem_addr);
        else n_pass++;
        q_a.push_back('{CH_BFS, fdat(9'h1A5), cyc + 1});
        tick(); a_req = 2'b00; settle();
        n_total++;
        if (a_gnt !== 2'b10 || a_mem_en !== 1'b0)
            $display("FAIL single_hold: gnt=%b en=%b, required 10 0", a_gnt, a_mem_en);
        else n_pass++;
        tick(); settle();
        n_total++;
        if (a_gnt !== 2'b00) $display("FAIL single_release: gnt=%b, required 00", a_gnt);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        tick();
        a_req = 2'b11; a_we = 2'b10; a_addr = {9'h020, 9'h010};
        a_wdata = {32'hCAFE_F00D, 32'h1111_1111};
        settle();
        for (int k = 1; k <= 2; k++) begin
            tick(); settle();
            n_total++;
            if (a_gnt !== 2'b01 || a_mem_en !== 1'b1 || a_mem_we !== 1'b0 ||
                a_mem_addr !== 9'h010 || a_mem_wdata !== 32'h1111_1111)
                $display("FAIL prio_ch0_c%0d: gnt=%b en=%b we=%b addr=%h wdata=%h, required 01 1 0 010 11111111",
                         k, a_gnt, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata);
            else n_pass++;
            q_a.push_back('{CH_OCTREE, fdat(9'h010), cyc + 1});
        end
        tick(); a_req = 2'b10; settle();
        n_total++;
        if (a_gnt !== 2'b01 || a_mem_en !== 1'b0)
            $display("FAIL prio_drop: gnt=%b en=%b, required 01 0", a_gnt, a_mem_en);
        else n_pass++;
        tick(); settle();
        n_total++;
        if (a_gnt !== 2'b10 || a_mem_en !== 1'b1 || a_mem_we !== 1'b1 ||
            a_mem_addr !== 9'h020 || a_mem_wdata !== 32'hCAFE_F00D)
            $display("FAIL prio_handover_write: gnt=%b en=%b we=%b addr=%h wdata=%h, required 10 1 1 020 cafef00d",
                     a_gnt, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata);
        else n_pass++;
        tick(); a_req = 2'b00; a_we = 2'b00; settle();
        tick(); settle();
        n_total++;
        if (a_gnt !== 2'b00) $display("FAIL prio_idle: gnt=%b, required 00", a_gnt);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [8:0] exp_ad;
        int ch;
        tick();
        b_req = 4'hF; b_addr = {9'h103, 9'h102, 9'h101, 9'h100};
        settle();
        for (int k = 0; k < 10; k++) begin
            tick(); settle();
            ch = (k / 2) % 4;
            exp_g = 4'b0001 << ch;
            exp_ad = 9'h100 + 9'(ch);
            n_total++;
            if (b_gnt !== exp_g || b_mem_en !== 1'b1 || b_mem_addr !== exp_ad)
                $display("FAIL rr_slot%0d: gnt=%b en=%b addr=%h, required %b 1 %h", k, b_gnt, b_mem_en, b_mem_addr, exp_g, exp_ad);
            else n_pass++;
        end
        tick(); b_req = 4'h0; settle();
        n_total++;
        if (b_gnt !== 4'b0010 || b_mem_en !== 1'b0)
            $display("FAIL rr_next_after_wrap: gnt=%b en=%b, required 0010 0", b_gnt, b_mem_en);
        else n_pass++;
        tick(); settle();
    endtask

    task automatic test_lock();
        logic pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tick();
        c_lock = 2'b01; c_req = 2'b11; c_we = 2'b00; c_addr = {9'h044, 9'h033};
        settle();
        for (int k = 0; k < 6; k++) begin
            tick(); c_req[0] = pat[k]; settle();
            n_total++;
            if (c_gnt !== 2'b01 || c_mem_en !== pat[k] || (pat[k] && c_mem_addr !== 9'h033))
                $display("FAIL lock_hold_c%0d: gnt=%b en=%b addr=%h, required 01 %b 033", k, c_gnt, c_mem_en, c_mem_addr, pat[k]);
            else n_pass++;
            if (pat[k]) q_c.push_back('{CH_OCTREE, fdat(9'h033), cyc + 3});
        end
        tick(); c_lock = 2'b00; c_req = 2'b10; settle();
        n_total++;
        if (c_gnt !== 2'b01 || c_mem_en !== 1'b0)
            $display("FAIL lock_drop: gnt=%b en=%b, required 01 0", c_gnt, c_mem_en);
        else n_pass++;
        tick(); settle();
        n_total++;
        if (c_gnt !== 2'b10 || c_mem_en !== 1'b1 || c_mem_addr !== 9'h044)
            $display("FAIL lock_handover: gnt=%b en=%b addr=%h, required 10 1 044", c_gnt, c_mem_en, c_mem_addr);
        else n_pass++;
        q_c.push_back('{CH_BFS, fdat(9'h044), cyc + 3});
        tick(); c_req = 2'b00; settle();
        tick(); settle();
        repeat (4) tick();
    endtask

    task automatic test_rd_latency();
        tick(); c_req = 2'b11; c_addr = {9'h0C3, 9'h061}; settle();
        tick(); settle();
        n_total++;
        if (c_gnt !== 2'b01 || c_mem_en !== 1'b1 || c_mem_addr !== 9'h061)
            $display("FAIL lat_ch0_a: gnt=%b en=%b addr=%h, required 01 1 061", c_gnt, c_mem_en, c_mem_addr);
        else n_pass++;
        q_c.push_back('{CH_OCTREE, fdat(9'h061), cyc + 3});
        tick(); c_addr = {9'h0C3, 9'h062}; settle();
        n_total++;
        if (c_gnt !== 2'b01 || c_mem_en !== 1'b1 || c_mem_addr !== 9'h062)
            $display("FAIL lat_ch0_b: gnt=%b en=%b addr=%h, required 01 1 062", c_gnt, c_mem_en, c_mem_addr);
        else n_pass++;
        q_c.push_back('{CH_OCTREE, fdat(9'h062), cyc + 3});
        tick(); c_req = 2'b10; settle();
        n_total++;
        if (c_gnt !== 2'b10 || c_mem_en !== 1'b1 || c_mem_addr !== 9'h0C3)
            $display("FAIL lat_cap_handover: gnt=%b en=%b addr=%h, required 10 1 0c3", c_gnt, c_mem_en, c_mem_addr);
        else n_pass++;
        q_c.push_back('{CH_BFS, fdat(9'h0C3), cyc + 3});
        tick(); c_req = 2'b00; settle();
        tick(); settle();
        n_total++;
        if (c_gnt !== 2'b00) $display("FAIL lat_idle: gnt=%b, required 00", c_gnt);
        else n_pass++;
        repeat (4) tick();
    endtask

    task automatic test_reset_midflight();
        tick(); c_req = 2'b01; c_lock = 2'b01; c_addr = {9'h000, 9'h07E}; settle();
        for (int k = 0; k < 3; k++) begin
            tick(); settle();
            n_total++;
            if (c_gnt !== 2'b01 || c_mem_en !== 1'b1)
                $display("FAIL mid_access_c%0d: gnt=%b en=%b, required 01 1", k, c_gnt, c_mem_en);
            else n_pass++;
        end
        // Two reads are now in the pipe; reset drops them.
        #2; rst_n = 1'b0; q_c.delete(); c_req = 2'b00; c_lock = 2'b00;
        #1;
        n_total++;
        if ({c_gnt, c_rvalid, c_mem_en, c_mem_we} !== 6'b0 || c_mem_addr !== 9'h0 || c_mem_wdata !== 32'h0)
            $display("FAIL mid_reset_outputs: gnt=%b rvalid=%b en=%b we=%b addr=%h wdata=%h, required all 0",
                     c_gnt, c_rvalid, c_mem_en, c_mem_we, c_mem_addr, c_mem_wdata);
        else n_pass++;
        @(negedge clk); #2; rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(); settle();
            n_total++;
            if (c_rvalid !== 2'b00 || c_gnt !== 2'b00)
                $display("FAIL mid_no_stale_c%0d: rvalid=%b gnt=%b, required 00 00", k, c_rvalid, c_gnt);
            else n_pass++;
        end
        tick(); c_req = 2'b10; c_addr = {9'h0AA, 9'h000}; settle();
        tick(); settle();
        n_total++;
        if (c_gnt !== 2'b10 || c_mem_en !== 1'b1 || c_mem_addr !== 9'h0AA)
            $display("FAIL mid_fresh_grant: gnt=%b en=%b addr=%h, required 10 1 0aa", c_gnt, c_mem_en, c_mem_addr);
        else n_pass++;
        q_c.push_back('{CH_BFS, fdat(9'h0AA), cyc + 3});
        tick(); c_req = 2'b00; settle();
        repeat (5) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            monitor_loop();
        join_none
        test_reset();
        test_single();
        test_simultaneous();
        test_round_robin();
        test_lock();
        test_rd_latency();
        test_reset_midflight();
        settle();
        n_total++;
        if (q_a.size() != 0 || q_c.size() != 0)
            $display("FAIL sb_drain: pending a=%0d c=%0d, required 0 0", q_a.size(), q_c.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
